// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST classification pipeline.
package mnist_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 9;
    localparam int IDX_W       = 4;

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } argmax_state_t;

endpackage

// File: rtl/fc_argmax_cmp.sv
// One step of a running top-2 search: folds score s_k into (best, best_idx, second).
module fc_argmax_cmp #(
    parameter int SCORE_W = mnist_pkg::SCORE_W,
    parameter int IDX_W   = mnist_pkg::IDX_W
) (
    input  logic [SCORE_W-1:0] s_k,
    input  logic [IDX_W-1:0]   k,
    input  logic [SCORE_W-1:0] best,
    input  logic [IDX_W-1:0]   best_idx,
    input  logic [SCORE_W-1:0] second,
    output logic [SCORE_W-1:0] best_nxt,
    output logic [IDX_W-1:0]   best_idx_nxt,
    output logic [SCORE_W-1:0] second_nxt
);

    // Strict comparisons keep the lowest index on ties and push the tied value into second.
    always_comb begin
        best_nxt     = best;
        best_idx_nxt = best_idx;
        second_nxt   = second;
        if (s_k > best) begin
            second_nxt   = best;
            best_nxt     = s_k;
            best_idx_nxt = k;
        end else if (s_k > second) begin
            second_nxt = s_k;
        end
    end

endmodule

// File: rtl/fc_argmax.sv
// Captures ten class scores and scans them one per clock to report winner, score and margin.
module fc_argmax #(
    parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
    parameter int SCORE_W     = mnist_pkg::SCORE_W,
    parameter int IDX_W       = mnist_pkg::IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [SCORE_W-1:0] fc_in_1,
    input  logic [SCORE_W-1:0] fc_in_2,
    input  logic [SCORE_W-1:0] fc_in_3,
    input  logic [SCORE_W-1:0] fc_in_4,
    input  logic [SCORE_W-1:0] fc_in_5,
    input  logic [SCORE_W-1:0] fc_in_6,
    input  logic [SCORE_W-1:0] fc_in_7,
    input  logic [SCORE_W-1:0] fc_in_8,
    input  logic [SCORE_W-1:0] fc_in_9,
    input  logic [SCORE_W-1:0] fc_in_10,
    output logic [IDX_W-1:0]   digit_out,
    output logic [SCORE_W-1:0] max_score,
    output logic [SCORE_W-1:0] margin,
    output logic               valid_out,
    output logic               busy,
    output logic               overrun
);

    import mnist_pkg::*;

    argmax_state_t      state;
    logic [SCORE_W-1:0] scores [NUM_CLASSES];
    logic [SCORE_W-1:0] fc_in  [NUM_CLASSES];
    logic [IDX_W-1:0]   k;
    logic [SCORE_W-1:0] best;
    logic [SCORE_W-1:0] second;
    logic [IDX_W-1:0]   best_idx;
    logic [SCORE_W-1:0] best_nxt;
    logic [SCORE_W-1:0] second_nxt;
    logic [IDX_W-1:0]   best_idx_nxt;
    logic               last_class;

    assign fc_in[0] = fc_in_1;
    assign fc_in[1] = fc_in_2;
    assign fc_in[2] = fc_in_3;
    assign fc_in[3] = fc_in_4;
    assign fc_in[4] = fc_in_5;
    assign fc_in[5] = fc_in_6;
    assign fc_in[6] = fc_in_7;
    assign fc_in[7] = fc_in_8;
    assign fc_in[8] = fc_in_9;
    assign fc_in[9] = fc_in_10;

    assign last_class = (k == IDX_W'(NUM_CLASSES - 1));

    fc_argmax_cmp #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_cmp (
        .s_k          (scores[k]),
        .k            (k),
        .best         (best),
        .best_idx     (best_idx),
        .second       (second),
        .best_nxt     (best_nxt),
        .best_idx_nxt (best_idx_nxt),
        .second_nxt   (second_nxt)
    );

    // Result of the final class goes straight from the comparator into the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            best      <= '0;
            second    <= '0;
            best_idx  <= '0;
            digit_out <= '0;
            max_score <= '0;
            margin    <= '0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                scores[i] <= '0;
            end
        end else begin
            valid_out <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            scores[i] <= fc_in[i];
                        end
                        best     <= fc_in[0];
                        best_idx <= '0;
                        second   <= '0;
                        k        <= IDX_W'(1);
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    overrun  <= valid_in;
                    best     <= best_nxt;
                    best_idx <= best_idx_nxt;
                    second   <= second_nxt;
                    k        <= k + 1'b1;
                    if (last_class) begin
                        digit_out <= best_idx_nxt;
                        max_score <= best_nxt;
                        margin    <= best_nxt - second_nxt;
                        valid_out <= 1'b1;
                        busy      <= 1'b0;
                        k         <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
